// File: rtl/bus_pkg.sv
// Shared bus definitions: bus_ctrl bit positions, control encodings and the
// transfer state machine encoding used by bus masters and arbiters.
package bus_pkg;

    // bus_ctrl bit positions
    localparam int unsigned EN       = 0;
    localparam int unsigned WE       = 1;
    localparam int unsigned GP_EN    = 2;
    localparam int unsigned TRISTATE = 3;

    // Whole-field encodings {tristate, gp_en, we, en}
    localparam logic [3:0] CTRL_IDLE  = 4'b0000;
    localparam logic [3:0] CTRL_READ  = 4'b0001;
    localparam logic [3:0] CTRL_WRITE = 4'b0011;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

endpackage

// File: rtl/rr_pick3.sv
// Three-way round-robin picker. Searches last_grant+1, +2, +3 (mod 3) and
// returns the first requesting index. Purely combinational.
module rr_pick3 (
    input  logic [2:0] req,
    input  logic [1:0] last_grant,
    output logic [1:0] winner,
    output logic       valid
);

    // Rotate the search order so the most recent winner is tried last
    always_comb begin
        winner = 2'd0;
        valid  = |req;
        case (last_grant)
            2'd0:    winner = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
            2'd1:    winner = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
            // 2 and the unused code 3 both restart the search at master 0
            default: winner = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
        endcase
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing the system memory bus between instruction
// fetch (0), data load/store (1) and the peripheral master (2). Each grant
// runs a fixed-latency access, then returns a one-cycle done pulse plus
// registered read data, followed by a one-cycle bus turnaround.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned N_REQ       = 3,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          req_we,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_wdata,
    input  logic [DATA_W-1:0]         bus_rdata,
    output logic [N_REQ-1:0]          gnt,
    output logic [N_REQ-1:0]          done,
    output logic [DATA_W-1:0]         rdata,
    output logic [ADDR_W-1:0]         bus_addr,
    output logic [DATA_W-1:0]         bus_wdata,
    output logic [3:0]                bus_ctrl,
    output logic                      busy
);

    localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       last_grant_q;
    logic [1:0]       cur_idx_q;

    logic [1:0]       pick_idx;
    logic             pick_valid;

    rr_pick3 u_pick (
        .req        (req),
        .last_grant (last_grant_q),
        .winner     (pick_idx),
        .valid      (pick_valid)
    );

    // Transfer FSM; every output is a register updated here
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= 2'd2;
            cur_idx_q    <= 2'd0;
            gnt          <= '0;
            done         <= '0;
            rdata        <= '0;
            bus_addr     <= '0;
            bus_wdata    <= '0;
            bus_ctrl     <= CTRL_IDLE;
            busy         <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        cur_idx_q <= pick_idx;
                        gnt       <= N_REQ'(1) << pick_idx;
                        bus_addr  <= req_addr[int'(pick_idx) * ADDR_W +: ADDR_W];
                        bus_wdata <= req_wdata[int'(pick_idx) * DATA_W +: DATA_W];
                        bus_ctrl  <= req_we[pick_idx] ? CTRL_WRITE : CTRL_READ;
                        cnt_q     <= CNT_W'(WAIT_CYCLES);
                        busy      <= 1'b1;
                        state_q   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        // The we bit still reflects the access being finished
                        if (!bus_ctrl[WE]) begin
                            rdata <= bus_rdata;
                        end
                        bus_ctrl     <= CTRL_IDLE;
                        done         <= gnt;
                        last_grant_q <= cur_idx_q;
                        state_q      <= DONE;
                    end
                end
                DONE: begin
                    done    <= '0;
                    gnt     <= '0;
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
